// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one full-adder cell sequenced LSB-first over two
// WIDTH-bit operands, with start/busy/done handshake and registered results.
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   opa_q, opa_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic [WIDTH-1:0]   partial_q, partial_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               carry_q, carry_d;
    logic               cout_q, cout_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [1:0]         fa;

    // Returns {carry, sum} of a single full-adder cell.
    function automatic logic [1:0] full_add(input logic x, input logic y, input logic c);
        return {(x & y) | (x & c) | (y & c), x ^ y ^ c};
    endfunction

    always_comb begin
        state_d   = state_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        partial_d = partial_q;
        sum_d     = sum_q;
        count_d   = count_q;
        carry_d   = carry_q;
        cout_d    = cout_q;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        fa        = full_add(opa_q[0], opb_q[0], carry_q);

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = RUN;
                    opa_d     = a;
                    opb_d     = b;
                    carry_d   = cin;
                    partial_d = '0;
                    count_d   = '0;
                    busy_d    = 1'b1;
                end
            end
            RUN: begin
                opa_d     = {1'b0, opa_q[WIDTH-1:1]};
                opb_d     = {1'b0, opb_q[WIDTH-1:1]};
                carry_d   = fa[1];
                partial_d = {fa[0], partial_q[WIDTH-1:1]};
                // Counter is frozen on the last step so it never wraps.
                if (count_q == LAST_STEP) begin
                    state_d = DONE;
                    sum_d   = {fa[0], partial_q[WIDTH-1:1]};
                    cout_d  = fa[1];
                    done_d  = 1'b1;
                end else begin
                    count_d = count_q + CNT_W'(1);
                    busy_d  = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            opa_q     <= '0;
            opb_q     <= '0;
            partial_q <= '0;
            sum_q     <= '0;
            count_q   <= '0;
            carry_q   <= 1'b0;
            cout_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            partial_q <= partial_d;
            sum_q     <= sum_d;
            count_q   <= count_d;
            carry_q   <= carry_d;
            cout_q    <= cout_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

Bit-serial adder controller that sequences a single full-adder cell (sum = a^b^c, carry = majority(a,b,c)) over two WIDTH-bit operands, one bit per clock, LSB first. The full-adder cell is the only arithmetic resource. The block owns the operand shift registers, the carry flip-flop, the bit counter and the start/busy/done handshake. It sits between a requester that supplies operand pairs and any consumer of the WIDTH-bit sum plus carry-out.

## Interface

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..32.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  reset; synchronous, active-high.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  operand A; captured on the accepted start edge.
- b  input  WIDTH  operand B; captured on the accepted start edge.
- cin  input  1  carry-in; captured on the accepted start edge; loads the carry flip-flop.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; sum and cout are valid in that cycle.
- sum  output  WIDTH  result register; updated only on entry to DONE.
- cout  output  1  final carry; updated only on entry to DONE.

## Operation

- **States:**
  - IDLE: waits for start.
  - RUN: processes WIDTH bit-steps.
  - DONE: single cycle, then returns to IDLE.
- **IDLE → RUN** on an edge with start=1:
  - opA←a, opB←b, carry←cin, partial←0, count←0.
- **RUN, each edge:** the full adder evaluates opA[0], opB[0], carry.
  - The sum bit shifts into partial[WIDTH-1] while partial shifts right.
  - opA and opB shift right with zero fill; carry←fa_carry; count←count+1.
- **RUN → DONE** on the edge where count==WIDTH-1 (the WIDTH-th step):
  - sum←final partial; cout←final carry.
- **DONE → IDLE** unconditionally on the next edge.
- **start is ignored in RUN and DONE.** There is no queuing. A start held high through DONE is accepted on the first IDLE edge.
- **Width and result rules:**
  - count is ceil(log2(WIDTH)) bits; it never wraps within one operation.
  - {cout,sum} == a+b+cin modulo 2^(WIDTH+1), exactly.
- **Output stability:**
  - sum and cout hold their last result through IDLE and the entire next RUN.
  - Outputs change only on DONE entry or on reset.
- **Reset** (any state, including mid-RUN):
  - State→IDLE.
  - busy=0, done=0, sum=0, cout=0, carry=0, count=0, operand and partial registers=0.
  - The in-flight operation is discarded; no done is produced.

## Timing

- Let edge E0 be the edge that accepts start:
  - busy=1 after E0 through edge E(WIDTH).
  - done=1 for exactly the cycle between E(WIDTH) and E(WIDTH+1).
- **Latency:** start accepted to done asserted is WIDTH cycles; the done pulse is 1 cycle.
- **Throughput:** one operation per WIDTH+2 cycles when start is held high (E0 accepted, next accepted at E(WIDTH+2)).
- busy and done are never high in the same cycle. Both are registered outputs.
- The full-adder logic is the only combinational path; operands feed it from registers, giving no input-to-output combinational path.

## Test plan

- **Basic add:** reset 2 cycles; WIDTH=8; a=0x3C, b=0x15, cin=0, pulse start → busy for 8 cycles, then done 1 cycle with sum=0x51, cout=0.
- **Full carry ripple:** a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1.
- **Carry-in propagation:** a=0xA5, b=0x5A, cin=1 → sum=0x00, cout=1.
- **Start while busy is ignored:** start a=0x01, b=0x01; re-pulse start with a=0xF0 at cycle 3 of RUN → a single done, with sum=0x02, cout=0. The previous sum is held unchanged during RUN.
- **Reset mid-operation:** start a=0xFF, b=0xFF; assert rst at cycle 4 of RUN → next cycle busy=0, sum=0x00, cout=0. No done appears afterwards. A new start of 0x10+0x20 then yields 0x30 after 8 cycles.
- **Back-to-back and randomized:** hold start=1 with 200 random a, b, cin → done every 10 cycles. Each {cout,sum} matches a reference sum a+b+cin. Repeat the run with WIDTH=2 and WIDTH=32.
